// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
// Optional door auto-close is enabled with ELEVATOR_DOOR_TIMEOUT_EN (see elevator_car_ctrl).
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_MOVE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width needed to hold 0..floors-1, never less than one bit.
  function automatic int pos_width(input int floors);
    return (floors > 1) ? $clog2(floors) : 1;
  endfunction

endpackage

// File: rtl/elevator_step_prescaler.sv
// Step prescaler: wraps 0..STEP_DIV-1 and flags the last count as one floor of travel.
// Held at 0 while clr is high so each move starts with a full step period.
module elevator_step_prescaler
  import elevator_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk_1hz,
  input  logic rst,
  input  logic clr,
  output logic step_tick
);

  localparam int            CW   = pos_width(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr || (count_q == LAST)) count_d = '0;
    else                          count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_1hz) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign step_tick = !clr && (count_q == LAST);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: IDLE/OPEN/MOVE sequencing with saturating floor position.
// Define ELEVATOR_DOOR_TIMEOUT_EN to close the door automatically after DOOR_HOLD cycles.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter  int FLOORS    = 4,
  parameter  int STEP_DIV  = 4,
  parameter  int DOOR_HOLD = 2,
  localparam int POS_W     = pos_width(FLOORS)
) (
  input  logic             clk_1hz,
  input  logic             rst,
  input  logic             stop,
  input  logic             run,
  input  logic             head,
  input  logic             door_close,
  output logic [POS_W-1:0] position,
  output logic             door,
  output logic             moving,
  output logic             dir,
  output logic             at_top,
  output logic             at_bottom,
  output logic             limit_err
);

  localparam logic [POS_W-1:0] TOP = POS_W'(FLOORS - 1);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             door_q, moving_q, at_top_q, at_bottom_q;
  logic             lerr_q, lerr_d;
  logic             presc_clr, step_tick, hold_done;

  assign presc_clr = (state_q != ST_MOVE);

  elevator_step_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .clr      (presc_clr),
    .step_tick(step_tick)
  );

`ifdef ELEVATOR_DOOR_TIMEOUT_EN
  localparam int            HW        = pos_width(DOOR_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DOOR_HOLD - 1);

  logic [HW-1:0] hold_q, hold_d;

  // Counter is zero outside OPEN, so entering OPEN always starts a fresh hold.
  always_comb begin
    hold_d = '0;
    if ((state_q == ST_OPEN) && !stop) hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk_1hz) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign hold_done = (state_q == ST_OPEN) && (hold_q == HOLD_LAST);
`else
  assign hold_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    lerr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_OPEN;
        end else if (run && door_close) begin
          if (((head == DIR_UP) && at_top_q) || ((head == DIR_DOWN) && at_bottom_q)) begin
            lerr_d = 1'b1;
          end else begin
            state_d = ST_MOVE;
            dir_d   = head;
          end
        end
      end
      ST_MOVE: begin
        if (step_tick) begin
          if (dir_q == DIR_UP) begin
            if (pos_q != TOP) pos_d = pos_q + 1'b1;
          end else begin
            if (pos_q != '0) pos_d = pos_q - 1'b1;
          end
          if (stop) begin
            state_d = ST_OPEN;
          end else if (((dir_q == DIR_UP) && (pos_d == TOP)) ||
                       ((dir_q == DIR_DOWN) && (pos_d == '0)) || !run) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (!stop && (door_close || hold_done)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      door_q      <= 1'b0;
      moving_q    <= 1'b0;
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b1;
      lerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      door_q      <= (state_d == ST_OPEN);
      moving_q    <= (state_d == ST_MOVE);
      at_top_q    <= (pos_d == TOP);
      at_bottom_q <= (pos_d == '0);
      lerr_q      <= lerr_d;
    end
  end

  assign position  = pos_q;
  assign door      = door_q;
  assign moving    = moving_q;
  assign dir       = dir_q;
  assign at_top    = at_top_q;
  assign at_bottom = at_bottom_q;
  assign limit_err = lerr_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl (FLOORS=4, STEP_DIV=4, DOOR_HOLD=2).
// Door auto-close expectations follow ELEVATOR_DOOR_TIMEOUT_EN.
module tb_elevator_car_ctrl;

  logic       clk_1hz = 1'b0;
  logic       rst, stop, run, head, door_close;
  logic [1:0] position;
  logic       door, moving, dir, at_top, at_bottom, limit_err;

  int n_cmp = 0;
  int n_bad = 0;

  elevator_car_ctrl #(.FLOORS(4), .STEP_DIV(4), .DOOR_HOLD(2)) dut (
    .clk_1hz   (clk_1hz),
    .rst       (rst),
    .stop      (stop),
    .run       (run),
    .head      (head),
    .door_close(door_close),
    .position  (position),
    .door      (door),
    .moving    (moving),
    .dir       (dir),
    .at_top    (at_top),
    .at_bottom (at_bottom),
    .limit_err (limit_err)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic step();
    @(negedge clk_1hz);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; run = 1'b0; head = 1'b0; door_close = 1'b0;
    step(); step();
    check("rst_position", position, 0);
    check("rst_door", door, 0);
    check("rst_moving", moving, 0);
    check("rst_dir", dir, 0);
    check("rst_at_top", at_top, 0);
    check("rst_at_bottom", at_bottom, 1);
    check("rst_limit_err", limit_err, 0);
    rst = 1'b0;

    // Full climb 0 -> 3
    run = 1'b1; door_close = 1'b1; head = 1'b1;
    step();
    check("up_moving", moving, 1);
    check("up_dir", dir, 1);
    repeat (3) step();
    check("up_pos_before_tick", position, 0);
    step();
    check("up_pos1", position, 1);
    check("up_moving_mid", moving, 1);
    repeat (4) step();
    check("up_pos2", position, 2);
    repeat (4) step();
    check("up_pos3", position, 3);
    check("top_moving", moving, 0);
    check("top_at_top", at_top, 1);
    check("top_at_bottom", at_bottom, 0);

    // Refused move past the top, persistent request re-pulses
    step();
    check("top_lerr1", limit_err, 1);
    check("top_pos_hold", position, 3);
    check("top_no_move", moving, 0);
    step();
    check("top_lerr2", limit_err, 1);
    run = 1'b0;
    step();
    check("top_lerr_clear", limit_err, 0);
    check("top_no_wrap", position, 3);

    // Down one floor, run dropped mid-step is ignored until the tick
    head = 1'b0; run = 1'b1;
    step();
    check("dn_moving", moving, 1);
    check("dn_dir", dir, 0);
    run = 1'b0; head = 1'b1;
    repeat (3) step();
    check("dn_still_moving", moving, 1);
    check("dn_pos_before_tick", position, 3);
    step();
    check("dn_pos2", position, 2);
    check("dn_idle", moving, 0);
    check("dn_at_top", at_top, 0);
    check("dn_dir_latched", dir, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_position", position, 0);

    // Stop raised at prescaler count 2
    run = 1'b1; door_close = 1'b1; head = 1'b1;
    step();
    check("stp_moving", moving, 1);
    step(); step();
    stop = 1'b1;
    step();
    check("stp_no_halt", moving, 1);
    check("stp_door_closed", door, 0);
    check("stp_pos_before", position, 0);
    step();
    check("stp_pos1", position, 1);
    check("stp_door_open", door, 1);
    check("stp_moving_off", moving, 0);

    // Stop wins over door_close
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("open_stop_wins", door, 1);
    end
    stop = 1'b0;
    step();
    check("open_close", door, 0);

    // Door open without a close request
    stop = 1'b1; door_close = 1'b0;
    step();
    check("hold_door_c1", door, 1);
    stop = 1'b0;
    step();
    check("hold_door_c2", door, 1);
    step();
`ifdef ELEVATOR_DOOR_TIMEOUT_EN
    check("hold_door_c3", door, 0);
    step();
    check("hold_door_c4", door, 0);
`else
    check("hold_door_c3", door, 1);
    step();
    check("hold_door_c4", door, 1);
`endif
    door_close = 1'b1;
    step();
    check("hold_door_closed", door, 0);

    // Reset mid-move from floor 1 at prescaler count 2
    run = 1'b1; head = 1'b1;
    step();
    check("rmv_moving", moving, 1);
    step(); step();
    rst = 1'b1;
    step();
    check("rmv_position", position, 0);
    check("rmv_moving_off", moving, 0);
    check("rmv_door", door, 0);
    check("rmv_at_bottom", at_bottom, 1);
    check("rmv_at_top", at_top, 0);
    rst = 1'b0; run = 1'b0;

    // Refused move past the bottom
    step();
    head = 1'b0; run = 1'b1;
    step();
    check("bot_lerr", limit_err, 1);
    check("bot_pos", position, 0);
    check("bot_no_move", moving, 0);
    run = 1'b0;
    step();
    check("bot_lerr_clear", limit_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
